mem_responder: RTL and testbench



---
 rtl/mem_responder_if.sv | 40 ++++
 rtl/mem_responder.sv | 135 +++++++++++++
 tb/tb_mem_responder.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response and RAM byte-port bundle for mem_responder.
// Defining FETCH32_EN adds req_size (0 = doubleword, 1 = word).
interface mem_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    // Handshakes: a transfer happens on a rising clk edge where valid && ready.
    // The producer holds valid and its payload stable until that edge.
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W:0]   req_data;
`ifdef FETCH32_EN
    logic              req_size;
`endif
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;

    modport slave (
`ifdef FETCH32_EN
        input  req_size,
`endif
        input  req_valid, req_addr, req_data, rsp_ready, ram_rdata,
        output req_ready, rsp_valid, rsp_data, rsp_err, ram_addr, ram_we, ram_wdata
    );

    modport master (
`ifdef FETCH32_EN
        output req_size,
`endif
        output req_valid, req_addr, req_data, rsp_ready, ram_rdata,
        input  req_ready, rsp_valid, rsp_data, rsp_err, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: serialises one 64-bit CPU access into big-endian byte beats on a byte RAM.
// Optional FETCH32_EN adds 4-byte word accesses selected by req_size.
module mem_responder #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int BEATS  = DATA_W / 8
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus,
    output logic [1:0]     dbg_state_o
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam int               CNT_W   = $clog2(BEATS) + 1;
    localparam logic [CNT_W-1:0] LAST_DW = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] LAST_WD = CNT_W'(BEATS / 2 - 1);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  last_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [7:0]        ram_wdata_q;

    logic              req_ready_w;
    logic              word_req;
    logic              misaligned;
    logic [DATA_W-1:0] wr_word;

`ifdef FETCH32_EN
    assign word_req = bus.req_size;
`else
    assign word_req = 1'b0;
`endif

    assign misaligned = word_req ? (bus.req_addr[1:0] != 2'b00)
                                 : (bus.req_addr[2:0] != 3'b000);
    // Word data is left-justified so both sizes stream out of the top byte.
    assign wr_word = word_req ? {bus.req_data[DATA_W/2-1:0], {(DATA_W/2){1'b0}}}
                              : bus.req_data[DATA_W-1:0];

    assign req_ready_w   = (state_q == IDLE) && !rst;
    assign bus.req_ready = req_ready_w;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign dbg_state_o   = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= '0;
            shift_q     <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid && req_ready_w) begin
                        cnt_q      <= '0;
                        last_q     <= word_req ? LAST_WD : LAST_DW;
                        rsp_data_q <= '0;
                        if (misaligned) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            state_q     <= RESP;
                        end else if (bus.req_data[DATA_W]) begin
                            ram_addr_q  <= bus.req_addr;
                            ram_we_q    <= 1'b1;
                            ram_wdata_q <= wr_word[DATA_W-1 -: 8];
                            shift_q     <= wr_word << 8;
                            state_q     <= WRITE;
                        end else begin
                            ram_addr_q <= bus.req_addr;
                            state_q    <= READ;
                        end
                    end
                end
                WRITE: begin
                    if (cnt_q == last_q) begin
                        ram_we_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        cnt_q       <= cnt_q + 1'b1;
                        ram_addr_q  <= ram_addr_q + ADDR_W'(1);
                        ram_wdata_q <= shift_q[DATA_W-1 -: 8];
                        shift_q     <= shift_q << 8;
                    end
                end
                READ: begin
                    // Addresses lead the returning bytes by two edges (RAM latch + sample).
                    if (cnt_q < last_q) begin
                        ram_addr_q <= ram_addr_q + ADDR_W'(1);
                    end
                    if (cnt_q != '0) begin
                        rsp_data_q <= {rsp_data_q[DATA_W-9:0], bus.ram_rdata};
                    end
                    if (cnt_q == last_q + 1'b1) begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: byte RAM model, reference memory model and
// directed plus randomized accesses; FETCH32_EN enables the word-access scenarios.
module tb_mem_responder;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;

    logic       clk;
    logic       rst;
    logic       ram_clear;
    logic [1:0] dbg_state;
    int         n_checks;
    int         n_fail;

    logic [7:0]        ram     [0:4095];
    logic [7:0]        ref_mem [0:4095];
    logic [DATA_W-1:0] exp_q   [$];

    mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (state=%0d)", dbg_state);
        $fatal(1);
    end

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 29) ^ (i >> 5));
    endfunction

    // Byte RAM with one-cycle synchronous read
    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 4096; i++) ram[i] <= init_byte(i);
        end else if (bus.ram_we) begin
            ram[bus.ram_addr[11:0]] <= bus.ram_wdata;
        end
        bus.ram_rdata <= ram[bus.ram_addr[11:0]];
    end

    // Reference model: big-endian byte i of an nb-byte access at address a
    function automatic logic [63:0] model_read(input logic [31:0] a, input int nb);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < nb; i++) v = (v << 8) | {56'b0, ref_mem[a[11:0] + 12'(i)]};
        return v;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [63:0] v, input int nb);
        for (int i = 0; i < nb; i++) ref_mem[a[11:0] + 12'(i)] = v[8*(nb-1-i) +: 8];
    endtask

    function automatic bit ram_matches(input logic [31:0] a, input int nb);
        for (int i = 0; i < nb; i++)
            if (ram[a[11:0] + 12'(i)] !== ref_mem[a[11:0] + 12'(i)]) return 1'b0;
        return 1'b1;
    endfunction

    // Driver: one request, response held for ready_delay cycles before rsp_ready.
    // lat = edges from accept edge to first visible rsp_valid; we_cycles = cycles with ram_we high.
    task automatic do_req(input logic [31:0] addr, input logic [63:0] data, input logic we,
                          input int ready_delay, output logic [63:0] got_data, output logic got_err,
                          output int lat, output int we_cycles);
        int guard;
        bus.req_addr  = addr;
        bus.req_data  = {we, data};
        bus.req_valid = 1'b1;
        guard = 0;
        while (!bus.req_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL req_accept: req_ready=%b required 1 (state=%0d)", bus.req_ready, dbg_state);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 0;
        we_cycles = 0;
        while (!bus.rsp_valid && lat < 40) begin
            if (bus.ram_we) we_cycles++;
            @(posedge clk); #1;
            lat++;
        end
        got_data = bus.rsp_data;
        got_err  = bus.rsp_err;
        for (int i = 0; i < ready_delay; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== got_data || bus.req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL rsp_hold: valid=%b data=%h ready=%b required 1/%h/0",
                         bus.rsp_valid, bus.rsp_data, bus.req_ready, got_data);
            end
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        n_checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rsp_release: rsp_valid=%b req_ready=%b required 0/1", bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 ||
            bus.rsp_data !== 64'h0 || bus.ram_we !== 1'b0 || bus.ram_addr !== 32'h0 ||
            bus.ram_wdata !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b valid=%b err=%b data=%h we=%b addr=%h wdata=%h required all 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.ram_we,
                     bus.ram_addr, bus.ram_wdata);
        end
        ram_clear = 1'b0;
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: req_ready=%b required 1", bus.req_ready);
        end
    endtask

    task automatic test_write_basic;
        logic [63:0] d;
        logic        e;
        int          lat, wec;
        model_write(32'h100, 64'h0123456789ABCDEF, 8);
        do_req(32'h100, 64'h0123456789ABCDEF, 1'b1, 0, d, e, lat, wec);
        n_checks++;
        if (lat !== 8) begin n_fail++; $display("FAIL write_latency: got %0d required 8", lat); end
        n_checks++;
        if (wec !== 8) begin n_fail++; $display("FAIL write_we_cycles: got %0d required 8", wec); end
        n_checks++;
        if (e !== 1'b0 || d !== 64'h0) begin
            n_fail++; $display("FAIL write_rsp: err=%b data=%h required 0/0", e, d);
        end
        n_checks++;
        if (!ram_matches(32'h100, 8) || ram[12'h100] !== 8'h01 || ram[12'h107] !== 8'hEF) begin
            n_fail++;
            $display("FAIL write_ram_bytes: ram[100]=%h ram[107]=%h required 01/EF", ram[12'h100], ram[12'h107]);
        end
    endtask

    task automatic test_read_basic;
        logic [63:0] d;
        logic        e;
        int          lat, wec;
        do_req(32'h100, 64'h0, 1'b0, 0, d, e, lat, wec);
        n_checks++;
        if (lat !== 9) begin n_fail++; $display("FAIL read_latency: got %0d required 9", lat); end
        n_checks++;
        if (wec !== 0) begin n_fail++; $display("FAIL read_no_we: got %0d we cycles required 0", wec); end
        n_checks++;
        if (e !== 1'b0 || d !== 64'h0123456789ABCDEF) begin
            n_fail++; $display("FAIL read_data: err=%b data=%h required 0/0123456789abcdef", e, d);
        end
    endtask

`ifdef FETCH32_EN
    task automatic test_fetch32;
        logic [63:0] d;
        logic        e;
        int          lat, wec;
        bus.req_size = 1'b1;
        do_req(32'h104, 64'h0, 1'b0, 0, d, e, lat, wec);
        n_checks++;
        if (lat !== 5 || e !== 1'b0 || d !== 64'h0000_0000_89AB_CDEF) begin
            n_fail++; $display("FAIL word_read: lat=%0d err=%b data=%h required 5/0/0000000089abcdef", lat, e, d);
        end
        do_req(32'h102, 64'h0, 1'b0, 0, d, e, lat, wec);
        n_checks++;
        if (lat !== 0 || e !== 1'b1 || d !== 64'h0 || wec !== 0) begin
            n_fail++; $display("FAIL word_misaligned: lat=%0d err=%b data=%h we=%0d required 0/1/0/0", lat, e, d, wec);
        end
        model_write(32'h300, 64'h0000_0000_CAFE_F00D, 4);
        do_req(32'h300, 64'h1234_5678_CAFE_F00D, 1'b1, 1, d, e, lat, wec);
        n_checks++;
        if (lat !== 4 || wec !== 4 || e !== 1'b0 || !ram_matches(32'h300, 8)) begin
            n_fail++; $display("FAIL word_write: lat=%0d we=%0d err=%b ram[300]=%h required 4/4/0/ca", lat, wec, e, ram[12'h300]);
        end
        bus.req_size = 1'b0;
    endtask
`endif

    task automatic test_misaligned;
        logic [63:0] d;
        logic        e;
        int          lat, wec;
        do_req(32'h103, 64'h0, 1'b0, 0, d, e, lat, wec);
        n_checks++;
        if (lat !== 0 || e !== 1'b1 || d !== 64'h0 || wec !== 0) begin
            n_fail++; $display("FAIL misaligned_read: lat=%0d err=%b data=%h we=%0d required 0/1/0/0", lat, e, d, wec);
        end
        do_req(32'h205, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2, d, e, lat, wec);
        n_checks++;
        if (e !== 1'b1 || wec !== 0 || !ram_matches(32'h200, 16)) begin
            n_fail++; $display("FAIL misaligned_write: err=%b we=%0d required 1/0 and RAM untouched", e, wec);
        end
    endtask

    task automatic test_backpressure;
        logic [63:0] snap;
        logic [31:0] addr_snap;
        int          guard;
        bit          ok;
        bus.req_addr  = 32'h100;
        bus.req_data  = {1'b0, 64'h0};
        bus.req_valid = 1'b1;
        guard = 0;
        while (!bus.req_ready && guard < 50) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        // A second (write) request stays asserted through the stalled response.
        bus.req_addr = 32'h400;
        bus.req_data = {1'b1, 64'hDEAD_BEEF_DEAD_BEEF};
        guard = 0;
        while (!bus.rsp_valid && guard < 40) begin @(posedge clk); #1; guard++; end
        n_checks++;
        if (guard !== 9 || bus.rsp_data !== model_read(32'h100, 8)) begin
            n_fail++; $display("FAIL bp_read: lat=%0d data=%h required 9/%h", guard, bus.rsp_data, model_read(32'h100, 8));
        end
        snap = bus.rsp_data;
        addr_snap = bus.ram_addr;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== snap || bus.req_ready !== 1'b0 ||
                bus.ram_we !== 1'b0 || bus.ram_addr !== addr_snap) ok = 1'b0;
        end
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL bp_stall: valid=%b data=%h req_ready=%b we=%b required 1/%h/0/0",
                               bus.rsp_valid, bus.rsp_data, bus.req_ready, bus.ram_we, snap);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        n_checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.ram_we !== 1'b0) begin
            n_fail++; $display("FAIL bp_release: valid=%b req_ready=%b we=%b required 0/1/0",
                               bus.rsp_valid, bus.req_ready, bus.ram_we);
        end
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        logic [63:0] d;
        logic        e;
        int          lat, wec, guard;
        bit          quiet;
        model_write(32'h200, 64'hA0A1_A2A3_A4A5_A6A7, 8);
        do_req(32'h200, 64'hA0A1_A2A3_A4A5_A6A7, 1'b1, 0, d, e, lat, wec);
        bus.req_addr  = 32'h200;
        bus.req_data  = {1'b1, 64'h1122_3344_5566_7788};
        bus.req_valid = 1'b1;
        guard = 0;
        while (!bus.req_ready && guard < 50) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.ram_we !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0 ||
            bus.ram_addr !== 32'h0 || bus.ram_wdata !== 8'h0 || bus.rsp_err !== 1'b0 || bus.rsp_data !== 64'h0) begin
            n_fail++; $display("FAIL midreset_outputs: we=%b valid=%b ready=%b addr=%h required all 0",
                               bus.ram_we, bus.rsp_valid, bus.req_ready, bus.ram_addr);
        end
        model_write(32'h200, 64'h0000_0000_0011_2233, 3);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (!ram_matches(32'h200, 8)) begin
            n_fail++; $display("FAIL midreset_ram: ram[202]=%h ram[203]=%h required 33/a3", ram[12'h202], ram[12'h203]);
        end
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) quiet = 1'b0;
        end
        n_checks++;
        if (!quiet) begin
            n_fail++; $display("FAIL midreset_no_rsp: rsp_valid=%b req_ready=%b required 0/1", bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic test_random;
        for (int t = 0; t < 40; t++) begin
            logic        word, we, err, e;
            logic [31:0] a;
            logic [63:0] wd, d, exp_d;
            int          nb, lat, wec, exp_lat, dly;
            word = 1'b0;
`ifdef FETCH32_EN
            word = 1'($urandom_range(0, 1));
            bus.req_size = word;
`endif
            nb = word ? 4 : 8;
            we = 1'($urandom_range(0, 1));
            a  = $urandom() & ~32'(nb - 1);
            if ($urandom_range(0, 4) == 0) a = a | 32'($urandom_range(1, nb - 1));
            wd  = {$urandom(), $urandom()};
            err = (a % 32'(nb)) != 0;
            if (err) begin
                exp_d = '0; exp_lat = 0;
            end else if (we) begin
                exp_d = '0; exp_lat = nb;
            end else begin
                exp_d = model_read(a, nb); exp_lat = nb + 1;
            end
            exp_q.push_back(exp_d);
            dly = $urandom_range(0, 3);
            do_req(a, wd, we, dly, d, e, lat, wec);
            exp_d = exp_q.pop_front();
            n_checks++;
            if (lat !== exp_lat || e !== err || d !== exp_d || wec !== ((!err && we) ? nb : 0)) begin
                n_fail++;
                $display("FAIL random[%0d]: addr=%h we=%b nb=%0d lat=%0d err=%b data=%h wecyc=%0d required %0d/%b/%h/%0d",
                         t, a, we, nb, lat, e, d, wec, exp_lat, err, exp_d, (!err && we) ? nb : 0);
            end
            if (!err && we) begin
                model_write(a, wd, nb);
                n_checks++;
                if (!ram_matches(a & ~32'h7, 8)) begin
                    n_fail++; $display("FAIL random_ram[%0d]: addr=%h ram[0]=%h required %h",
                                       t, a, ram[a[11:0]], ref_mem[a[11:0]]);
                end
            end
        end
`ifdef FETCH32_EN
        bus.req_size = 1'b0;
`endif
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        ram_clear     = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b0;
`ifdef FETCH32_EN
        bus.req_size  = 1'b0;
`endif
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_byte(i);
        test_reset;
        test_write_basic;
        test_read_basic;
`ifdef FETCH32_EN
        test_fetch32;
`endif
        test_misaligned;
        test_backpressure;
        test_reset_mid;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
